// File: rtl/ysyx_24110006_pkg.sv
// Shared writeback definitions: CSR addresses, csr_t encodings, mstatus bits, FSM states.
package ysyx_24110006_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_MRET = 2'b11
  } csr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TRAP = 1'b1
  } wbu_state_t;

  typedef struct packed {
    logic        vld;
    logic [11:0] addr;
    logic [31:0] dat;
  } csr_wr_t;

endpackage

// File: rtl/ysyx_24110006_csr_file.sv
// Machine CSR storage: combinational read, write/trap/mret/retire updates at the clock edge.
// Latency: reads 0 cycles, updates visible next cycle; no backpressure.
module ysyx_24110006_csr_file
  import ysyx_24110006_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [11:0] rd_addr,
  output logic [31:0] rd_dat,
  input  csr_wr_t     wr,
  input  logic        retire_vld,
  input  logic        trap_vld,
  input  logic [31:0] trap_pc,
  input  logic [3:0]  trap_cause,
  input  logic        mret_vld,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [63:0] minstret_q;
  logic        minstret_wr;

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

  always_comb begin
    rd_dat = 32'h0;
    case (rd_addr)
      CSR_MSTATUS:   rd_dat = mstatus_q;
      CSR_MTVEC:     rd_dat = mtvec_q;
      CSR_MEPC:      rd_dat = mepc_q;
      CSR_MCAUSE:    rd_dat = mcause_q;
      CSR_MINSTRET:  rd_dat = minstret_q[31:0];
      CSR_MINSTRETH: rd_dat = minstret_q[63:32];
      default:       rd_dat = 32'h0;
    endcase
  end

  // An explicit write to either minstret half wins over this cycle's increment.
  assign minstret_wr = wr.vld && ((wr.addr == CSR_MINSTRET) || (wr.addr == CSR_MINSTRETH));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      minstret_q <= 64'h0;
    end else begin
      if (wr.vld) begin
        case (wr.addr)
          CSR_MSTATUS:   mstatus_q <= wr.dat;
          CSR_MTVEC:     mtvec_q <= wr.dat;
          CSR_MEPC:      mepc_q <= wr.dat;
          CSR_MCAUSE:    mcause_q <= wr.dat;
          CSR_MINSTRET:  minstret_q[31:0] <= wr.dat;
          CSR_MINSTRETH: minstret_q[63:32] <= wr.dat;
          default: ;
        endcase
      end
      if (retire_vld && !minstret_wr) begin
        minstret_q <= minstret_q + 64'd1;
      end
      if (trap_vld) begin
        mepc_q                  <= trap_pc;
        mcause_q                <= {28'b0, trap_cause};
        mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
        mstatus_q[MSTATUS_MIE]  <= 1'b0;
      end
      if (mret_vld) begin
        mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
        mstatus_q[MSTATUS_MPIE] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_24110006_wbu.sv
// Writeback: same-cycle rf/CSR commit; traps and mret flush one cycle later (o_ready low that cycle).
// Optional WBU_DIFFTEST_EN adds o_commit/o_commit_pc retire tracing.
module ysyx_24110006_wbu
  import ysyx_24110006_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_reg_rd,
  input  logic        i_reg_wen,
  input  logic [1:0]  i_csr_t,
  input  logic [11:0] i_csr,
  input  logic        i_exception,
  input  logic [3:0]  i_mcause,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_flush,
  output logic [31:0] o_redirect_pc
`ifdef WBU_DIFFTEST_EN
  ,
  output logic        o_commit,
  output logic [31:0] o_commit_pc
`endif
);

  wbu_state_t  state_q, state_d;
  csr_t        csr_op;
  logic        accept;
  logic        trap_exc_q;
  logic [31:0] trap_pc_q;
  logic [3:0]  trap_cause_q;
  logic [31:0] csr_rd_dat;
  csr_wr_t     csr_wr;
  logic        retire_vld;
  logic        trap_vld;
  logic        mret_vld;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  assign csr_op  = csr_t'(i_csr_t);
  assign o_ready = (state_q == ST_IDLE) && !i_reset;
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d       = state_q;
    o_flush       = 1'b0;
    o_redirect_pc = 32'h0;
    o_rf_wen      = 1'b0;
    o_rf_waddr    = 5'h0;
    o_rf_wdata    = 32'h0;
    csr_wr        = '0;
    retire_vld    = 1'b0;
    trap_vld      = 1'b0;
    mret_vld      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_exception || (csr_op == CSR_MRET)) begin
            state_d = ST_TRAP;
          end else begin
            o_rf_wen    = i_reg_wen && (i_reg_rd != 5'd0);
            o_rf_waddr  = i_reg_rd;
            o_rf_wdata  = (csr_op == CSR_NONE) ? i_result : csr_rd_dat;
            csr_wr.vld  = (csr_op != CSR_NONE);
            csr_wr.addr = i_csr;
            csr_wr.dat  = (csr_op == CSR_RW) ? i_result : (csr_rd_dat | i_result);
            retire_vld  = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        state_d = ST_IDLE;
        // Reset landing on the trap cycle drops it entirely: no flush, no CSR side effects.
        if (!i_reset) begin
          o_flush       = 1'b1;
          o_redirect_pc = trap_exc_q ? {mtvec[31:2], 2'b00} : mepc;
          trap_vld      = trap_exc_q;
          mret_vld      = !trap_exc_q;
          retire_vld    = !trap_exc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      trap_exc_q   <= 1'b0;
      trap_pc_q    <= 32'h0;
      trap_cause_q <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept && (state_d == ST_TRAP)) begin
        trap_exc_q   <= i_exception;
        trap_pc_q    <= i_pc;
        trap_cause_q <= i_mcause;
      end
    end
  end

  ysyx_24110006_csr_file #(
    .MTVEC_RST(MTVEC_RST)
  ) u_csr (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .rd_addr   (i_csr),
    .rd_dat    (csr_rd_dat),
    .wr        (csr_wr),
    .retire_vld(retire_vld),
    .trap_vld  (trap_vld),
    .trap_pc   (trap_pc_q),
    .trap_cause(trap_cause_q),
    .mret_vld  (mret_vld),
    .mtvec     (mtvec),
    .mepc      (mepc)
  );

`ifdef WBU_DIFFTEST_EN
  assign o_commit    = retire_vld || trap_vld;
  assign o_commit_pc = (state_q == ST_TRAP) ? trap_pc_q : i_pc;
`endif

endmodule
